// File: rtl/lilme_mxv_engine.sv
`default_nettype none
//============================================================================
// Module   : lilme_mxv_engine
// Purpose  : Command-driven signed matrix x vector engine, y = A*b.
//            Loads A (ROW x COL, row-major) and b (COL) from word-addressed
//            memory, computes y with one MAC per cycle and stores y (ROW
//            words) back to memory.
// Ports    : clk, reset (async, active-low)
//            cmd_valid/cmd_ready/cmd_op/cmd_addr : host command channel
//            mem_req/mem_gnt/mem_we/mem_addr/mem_wdata : memory request
//            mem_rdata/mem_rvalid                : memory read return
//            busy, done (1-cycle), err (1-cycle, illegal opcode)
// Options  : LILME_SAT_EN - STORE saturates y to the signed DW range;
//            otherwise STORE writes the low DW bits of y.
// Revision : 1.0 - initial release
//============================================================================
module lilme_mxv_engine #(
   parameter int AW  = 32,
   parameter int DW  = 16,
   parameter int ROW = 4,
   parameter int COL = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [AW-1:0] cmd_addr,
   output logic          mem_req,
   input  logic          mem_gnt,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_rvalid,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int ACCW = 2*DW + $clog2(COL);
   localparam int NA   = ROW*COL;
   localparam int IW   = (NA  > 1) ? $clog2(NA)  : 1;
   localparam int RW   = (ROW > 1) ? $clog2(ROW) : 1;
   localparam int CW   = (COL > 1) ? $clog2(COL) : 1;

   localparam logic [2:0] C_OP_NOP    = 3'b000;
   localparam logic [2:0] C_OP_LOAD_A = 3'b001;
   localparam logic [2:0] C_OP_LOAD_B = 3'b010;
   localparam logic [2:0] C_OP_MULT   = 3'b011;
   localparam logic [2:0] C_OP_STORE  = 3'b100;
   localparam logic [2:0] C_OP_CLEAR  = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_MAC     = 3'd3,
      S_WR_REQ  = 3'd4,
      S_FIN     = 3'd5
   } state_t;

   state_t r_state, w_state_nxt;

   logic [2:0]             r_op;
   logic [AW-1:0]          r_base;
   logic [IW-1:0]          r_idx;     // word index for loads and stores
   logic [RW-1:0]          r_row;
   logic [CW-1:0]          r_col;
   logic signed [ACCW-1:0] r_acc;
   logic signed [DW-1:0]   r_a [NA];
   logic signed [DW-1:0]   r_b [COL];
   logic signed [ACCW-1:0] r_y [ROW];

   logic                   w_illegal;
   logic                   w_last_rd;
   logic                   w_last_wr;
   logic                   w_last_mac;
   logic [AW-1:0]          w_addr;
   logic [IW-1:0]          w_a_idx;
   logic signed [2*DW-1:0] w_prod;
   logic signed [ACCW-1:0] w_acc_base;
   logic signed [ACCW-1:0] w_acc_nxt;
   logic [DW-1:0]          w_fmt;

   assign w_illegal  = r_op[2] & r_op[1];
   assign w_last_rd  = (r_op == C_OP_LOAD_A) ? (r_idx == IW'(NA-1)) : (r_idx == IW'(COL-1));
   assign w_last_wr  = (r_idx == IW'(ROW-1));
   assign w_last_mac = (r_row == RW'(ROW-1)) && (r_col == CW'(COL-1));
   // base + index wraps modulo 2^AW by construction
   assign w_addr     = r_base + AW'(r_idx);

   assign w_a_idx    = IW'(r_row) * IW'(COL) + IW'(r_col);
   assign w_prod     = r_a[w_a_idx] * r_b[r_col];
   assign w_acc_base = (r_col == '0) ? '0 : r_acc;
   assign w_acc_nxt  = w_acc_base + ACCW'(w_prod);

`ifdef LILME_SAT_EN
   localparam logic signed [ACCW-1:0] C_SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACCW-1:0] C_SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
   logic signed [ACCW-1:0] w_wr_y;
   assign w_wr_y = r_y[RW'(r_idx)];
   always_comb begin
      if (w_wr_y > C_SAT_MAX)      w_fmt = C_SAT_MAX[DW-1:0];
      else if (w_wr_y < C_SAT_MIN) w_fmt = C_SAT_MIN[DW-1:0];
      else                         w_fmt = w_wr_y[DW-1:0];
   end
`else
   assign w_fmt = DW'(r_y[RW'(r_idx)]);
`endif

   assign busy = ~cmd_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      done        = 1'b0;
      err         = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               case (cmd_op)
                  C_OP_LOAD_A, C_OP_LOAD_B: w_state_nxt = S_RD_REQ;
                  C_OP_MULT:                w_state_nxt = S_MAC;
                  C_OP_STORE:               w_state_nxt = S_WR_REQ;
                  default:                  w_state_nxt = S_FIN;
               endcase
            end
         end
         S_RD_REQ: begin
            mem_req  = 1'b1;
            mem_addr = w_addr;
            if (mem_gnt) w_state_nxt = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (mem_rvalid) w_state_nxt = w_last_rd ? S_FIN : S_RD_REQ;
         end
         S_MAC: begin
            if (w_last_mac) w_state_nxt = S_FIN;
         end
         S_WR_REQ: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = w_addr;
            mem_wdata = w_fmt;
            if (mem_gnt && w_last_wr) w_state_nxt = S_FIN;
         end
         S_FIN: begin
            err         = w_illegal;
            done        = ~w_illegal;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op   <= '0;
         r_base <= '0;
         r_idx  <= '0;
         r_row  <= '0;
         r_col  <= '0;
         r_acc  <= '0;
         for (int i = 0; i < NA;  i++) r_a[i] <= '0;
         for (int i = 0; i < COL; i++) r_b[i] <= '0;
         for (int i = 0; i < ROW; i++) r_y[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_op   <= cmd_op;
                  r_base <= cmd_addr;
                  r_idx  <= '0;
                  r_row  <= '0;
                  r_col  <= '0;
                  if (cmd_op == C_OP_CLEAR) begin
                     for (int i = 0; i < NA;  i++) r_a[i] <= '0;
                     for (int i = 0; i < COL; i++) r_b[i] <= '0;
                     for (int i = 0; i < ROW; i++) r_y[i] <= '0;
                  end
               end
            end
            S_RD_WAIT: begin
               if (mem_rvalid) begin
                  if (r_op == C_OP_LOAD_A) r_a[r_idx]     <= mem_rdata;
                  else                     r_b[CW'(r_idx)] <= mem_rdata;
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_MAC: begin
               // accumulator restarts at c=0 and commits to y[r] at c=COL-1
               r_acc <= w_acc_nxt;
               if (r_col == CW'(COL-1)) begin
                  r_y[r_row] <= w_acc_nxt;
                  r_col      <= '0;
                  r_row      <= r_row + 1'b1;
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end
            S_WR_REQ: begin
               if (mem_gnt) r_idx <= r_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lilme_mxv_engine.sv
`default_nettype none
//============================================================================
// Module   : tb_lilme_mxv_engine
// Purpose  : Self-checking bench for lilme_mxv_engine (AW=32, DW=16, 4x4).
//            Memory responder with random grant / read-return delays;
//            expected reads and writes are queued as commands are issued
//            and compared against the transactions the engine performs.
// Options  : LILME_SAT_EN selects the saturating expectations.
// Revision : 1.0 - initial release
//============================================================================
module tb_lilme_mxv_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_addr;
   logic        mem_req;
   logic        mem_gnt;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_rvalid;
   logic        busy;
   logic        done;
   logic        err;

   lilme_mxv_engine #(.AW(32), .DW(16), .ROW(4), .COL(4)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] a [16];
      logic [15:0] b [4];
      logic [15:0] y [4];
   } vec_t;

   logic [15:0] mem [logic [31:0]];
   logic [31:0] obs_rd [$];
   logic [47:0] obs_wr [$];
   logic [31:0] exp_rd [$];
   logic [47:0] exp_wr [$];
   bit          stray_en = 1'b0;
   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic logic [15:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 16'h0000;
   endfunction

   // memory responder: all drive at negedge, seen by the engine at posedge
   int          gnt_wait = 0;
   int          rd_cnt   = 0;
   bit          rd_pend  = 1'b0;
   logic [31:0] rd_addr  = '0;
   always @(negedge clk) begin
      if (!reset) begin
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
         rd_pend = 1'b0; gnt_wait = 0;
      end else begin
         mem_gnt = 1'b0; mem_rvalid = 1'b0;
         if (rd_pend) begin
            if (rd_cnt == 0) begin
               mem_rvalid = 1'b1; mem_rdata = mem_rd(rd_addr); rd_pend = 1'b0;
            end else rd_cnt--;
         end else if (stray_en) begin
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = 16'($urandom);
         end
         if (mem_req) begin
            if (gnt_wait == 0) begin
               mem_gnt  = 1'b1;
               gnt_wait = $urandom_range(0, 3);
               if (mem_we) obs_wr.push_back({mem_addr, mem_wdata});
               else begin
                  obs_rd.push_back(mem_addr);
                  rd_pend = 1'b1; rd_addr = mem_addr; rd_cnt = $urandom_range(0, 3);
               end
            end else gnt_wait--;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [31:0] addr,
                          output int cyc, output bit got_done, output bit got_err);
      int t = 0;
      cyc = -1; got_done = 1'b0; got_err = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr;
      while (!cmd_ready && t < 2000) begin @(negedge clk); t++; end
      if (!cmd_ready) begin
         chk("accept_timeout", 0, 1); cmd_valid = 1'b0; return;
      end
      @(posedge clk); #1 cmd_valid = 1'b0;
      cyc = 0;
      while (!(got_done || got_err) && cyc < 4000) begin
         @(negedge clk); cyc++; got_done = done; got_err = err;
      end
      if (!(got_done || got_err)) chk("done_timeout", 0, 1);
   endtask

   task automatic cmp_rd(input string nm);
      logic [31:0] e;
      while (exp_rd.size() > 0) begin
         e = exp_rd.pop_front();
         if (obs_rd.size() == 0) chk({nm, "_rd_missing"}, 0, 1);
         else chk({nm, "_rd_addr"}, 64'(obs_rd.pop_front()), 64'(e));
      end
      chk({nm, "_rd_extra"}, 64'(obs_rd.size()), 0);
      obs_rd.delete();
   endtask

   task automatic cmp_wr(input string nm);
      logic [47:0] e;
      while (exp_wr.size() > 0) begin
         e = exp_wr.pop_front();
         if (obs_wr.size() == 0) chk({nm, "_wr_missing"}, 0, 1);
         else chk({nm, "_wr_addr_data"}, 64'(obs_wr.pop_front()), 64'(e));
      end
      chk({nm, "_wr_extra"}, 64'(obs_wr.size()), 0);
      obs_wr.delete();
   endtask

   task automatic do_load(input logic [2:0] op, input logic [31:0] base, input int n, input string nm);
      int cyc; bit d, e;
      for (int i = 0; i < n; i++) exp_rd.push_back(base + 32'(i));
      run_cmd(op, base, cyc, d, e);
      chk({nm, "_done"}, {63'd0, d}, 1);
      cmp_rd(nm);
   endtask

   task automatic do_mult(input string nm);
      int cyc; bit d, e;
      run_cmd(3'b011, 32'h0, cyc, d, e);
      chk({nm, "_mult_done"}, {62'd0, d, e}, 2'b10);
      chk({nm, "_mult_latency"}, 64'(cyc), 17);
   endtask

   task automatic do_store(input logic [31:0] base, input logic [15:0] y [4], input string nm);
      int cyc; bit d, e;
      for (int r = 0; r < 4; r++) exp_wr.push_back({base + 32'(r), y[r]});
      run_cmd(3'b100, base, cyc, d, e);
      chk({nm, "_store_done"}, {63'd0, d}, 1);
      cmp_wr(nm);
   endtask

   vec_t        vecs [5];
   logic [15:0] zeros [4] = '{default: 16'h0};

   initial begin
      int  cyc, t, d1, d2;
      bit  d, e, seen;
      logic rdy_mid;

      // ---------------- vector table ----------------
      for (int i = 0; i < 16; i++) begin
         vecs[0].a[i] = 16'(i + 1);  vecs[1].a[i] = 16'(i + 1);
         vecs[2].a[i] = 16'h7FFF;    vecs[3].a[i] = 16'hFFFF;  vecs[4].a[i] = 16'h8000;
      end
      vecs[0].name = "ramp_ones"; vecs[0].b = '{16'd1, 16'd1, 16'd1, 16'd1};
      vecs[0].y = '{16'd10, 16'd26, 16'd42, 16'd58};
      vecs[1].name = "ramp_e0";   vecs[1].b = '{16'd1, 16'd0, 16'd0, 16'd0};
      vecs[1].y = '{16'd1, 16'd5, 16'd9, 16'd13};
      vecs[2].name = "max_pos";   vecs[2].b = '{default: 16'h7FFF};
      vecs[3].name = "neg_ones";  vecs[3].b = '{16'd1, 16'd2, 16'd3, 16'd4};
      vecs[3].y = '{default: 16'hFFF6};
      vecs[4].name = "max_neg";   vecs[4].b = '{default: 16'h8000};
`ifdef LILME_SAT_EN
      vecs[2].y = '{default: 16'h7FFF};
      vecs[4].y = '{default: 16'h7FFF};
`else
      vecs[2].y = '{default: 16'h0004};
      vecs[4].y = '{default: 16'h0000};
`endif

      // ---------------- reset state ----------------
      reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", {63'd0, cmd_ready}, 1);
      chk("rst_busy_done_err", {61'd0, busy, done, err}, 0);
      chk("rst_mem_req_we", {62'd0, mem_req, mem_we}, 0);
      chk("rst_mem_addr_wdata", {16'd0, mem_addr, mem_wdata}, 0);
      reset = 1'b1;

      // ---------------- reset mid LOAD_A ----------------
      for (int i = 0; i < 16; i++) mem[32'h100 + 32'(i)] = vecs[0].a[i];
      for (int i = 0; i < 4; i++)  mem[32'h200 + 32'(i)] = 16'd1;
      @(negedge clk); cmd_valid = 1'b1; cmd_op = 3'b001; cmd_addr = 32'h100;
      @(posedge clk); #1 cmd_valid = 1'b0;
      t = 0;
      while (obs_rd.size() < 3 && t < 500) begin @(negedge clk); t++; end
      chk("abort_saw_3_grants", {63'd0, obs_rd.size() >= 3}, 1);
      #2 reset = 1'b0;
      #1 chk("abort_mem_req", {63'd0, mem_req}, 0);
      chk("abort_busy", {62'd0, busy, cmd_ready}, 2'b01);
      @(negedge clk); @(negedge clk); reset = 1'b1;
      seen = 1'b0;
      repeat (6) begin @(negedge clk); seen |= done | err | mem_req; end
      chk("abort_no_done", {63'd0, seen}, 0);
      obs_rd.delete(); obs_wr.delete();
      // A cleared by reset: b = ones, so y must be all zero
      do_load(3'b010, 32'h200, 4, "abort_ldb");
      do_mult("abort");
      do_store(32'h300, zeros, "abort_zero");

      // ---------------- table-driven full flows ----------------
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 16; i++) mem[32'h100 + 32'(i)] = vecs[k].a[i];
         for (int i = 0; i < 4; i++)  mem[32'h200 + 32'(i)] = vecs[k].b[i];
         do_load(3'b001, 32'h100, 16, {vecs[k].name, "_lda"});
         do_load(3'b010, 32'h200, 4,  {vecs[k].name, "_ldb"});
         do_mult(vecs[k].name);
         do_store(32'h300, vecs[k].y, vecs[k].name);
      end

      // ---------------- address wrap ----------------
      do_load(3'b010, 32'hFFFF_FFFE, 4, "wrap");

      // ---------------- illegal opcode ----------------
      @(negedge clk); cmd_valid = 1'b1; cmd_op = 3'b110; cmd_addr = 32'h0;
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("illegal_err_pulse", {61'd0, err, done, cmd_ready}, 3'b100);
      @(negedge clk);
      chk("illegal_recover", {61'd0, err, done, cmd_ready}, 3'b001);

      // ---------------- command held off during MULT ----------------
      for (int i = 0; i < 16; i++) mem[32'h100 + 32'(i)] = vecs[0].a[i];
      for (int i = 0; i < 4; i++)  mem[32'h200 + 32'(i)] = vecs[0].b[i];
      do_load(3'b001, 32'h100, 16, "hold_lda");
      do_load(3'b010, 32'h200, 4,  "hold_ldb");
      @(negedge clk); cmd_valid = 1'b1; cmd_op = 3'b011;
      @(posedge clk); #1 cmd_op = 3'b000;   // NOP presented while busy
      cyc = 0; d1 = -1; d2 = -1; rdy_mid = 1'bx;
      while (cyc < 25) begin
         @(negedge clk); cyc++;
         if (cyc == 5) rdy_mid = cmd_ready;
         if (done) begin if (d1 < 0) d1 = cyc; else if (d2 < 0) d2 = cyc; end
         if (cyc == 19) cmd_valid = 1'b0;
      end
      cmd_valid = 1'b0;
      chk("hold_ready_in_mac", {63'd0, rdy_mid}, 0);
      chk("hold_mult_done_cyc", 64'(d1), 17);
      chk("hold_nop_done_cyc", 64'(d2), 19);

      // ---------------- stray rvalid in MAC, then CLEAR ----------------
      stray_en = 1'b1;
      do_mult("stray");
      stray_en = 1'b0;
      do_store(32'h300, vecs[0].y, "stray");
      run_cmd(3'b101, 32'h0, cyc, d, e);
      chk("clear_done", {62'd0, d, e}, 2'b10);
      chk("clear_latency", 64'(cyc), 1);
      run_cmd(3'b000, 32'h0, cyc, d, e);
      chk("nop_latency", 64'(cyc), 1);
      do_store(32'h380, zeros, "clear");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lilme_mxv_engine.md
Name: lilme_mxv_engine

Overview:
- Parametrised successor of the LilME matrix engine: a command-driven matrix × vector multiply-accumulate engine, y = A·b.
- Loads matrix A (ROW×COL) and vector b (COL) from word-addressed memory and computes y with one signed MAC per cycle.
- Writes y (ROW words) back to memory.
- Sits between the host command path and the shared memory port; adds ready/valid commands, a memory request/grant handshake and error reporting.

Parameters:
- AW, 32, memory address width in bits.
- DW, 16, data word width in bits; signed two's complement.
- ROW, 4, matrix rows and result vector length (≥1).
- COL, 4, matrix columns and b vector length (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  3  opcode.
- cmd_addr  in  AW  base word address for the command.
- mem_req  out  1  memory request.
- mem_gnt  in  1  request accepted this cycle.
- mem_we  out  1  1=write, 0=read.
- mem_addr  out  AW  word address.
- mem_wdata  out  DW  write data.
- mem_rdata  in  DW  read data.
- mem_rvalid  in  1  read data valid.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse on an illegal opcode.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; A, b, y registers cleared to 0; cmd_ready=1; busy, done, err, mem_req, mem_we=0; mem_addr, mem_wdata=0.
  - Reset asserted mid-command aborts it immediately, with no done pulse.
  - mem_req deasserts without waiting for mem_gnt.
- Command accept: cmd_valid & cmd_ready at an edge latches op/addr. cmd_ready = (state==IDLE); busy = !cmd_ready.
- Opcodes:
  - 000 NOP: done pulse on the next cycle.
  - 001 LOAD_A: read ROW*COL words from cmd_addr+i, row-major; word i → A[i/COL][i%COL].
  - 010 LOAD_B: read COL words from cmd_addr+i → b[i].
  - 011 MULT: y[r] = Σc A[r][c]·b[c].
  - 100 STORE: write y[r] to cmd_addr+r, r=0..ROW-1.
  - 101 CLEAR: zero A, b, y in one cycle, then done.
  - 110, 111: err pulse next cycle; no state change; no done pulse.
- FSM states: IDLE, RD_REQ, RD_WAIT, MAC, WR_REQ, FIN.
  - IDLE → RD_REQ (LOAD_*), MAC (MULT), WR_REQ (STORE), FIN (NOP/CLEAR/illegal).
  - RD_REQ: mem_req=1, mem_we=0; hold addr until mem_gnt → RD_WAIT.
  - RD_WAIT: on mem_rvalid store the word; → RD_REQ if words remain, else FIN. At most one read outstanding.
  - MAC: one product per cycle, ROW*COL cycles, r outer loop, c inner loop. The accumulator clears at c=0 and commits to y[r] at c=COL-1 → FIN.
  - WR_REQ: mem_req=1, mem_we=1, mem_wdata=y[r] formatted to DW; advance on mem_gnt; after the last word → FIN.
  - FIN: done=1 (err=1 instead for illegal op) for exactly one cycle → IDLE.
- Latency:
  - MULT: ROW*COL+1 cycles from accept to done.
  - NOP/CLEAR: 1 cycle from accept to done.
  - Memory commands: data-dependent on mem_gnt/mem_rvalid.
- Memory handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1 and mem_gnt=0.
  - mem_rvalid outside RD_WAIT is ignored.
  - mem_rvalid in the same cycle as mem_gnt is not expected; rvalid is honoured only from the cycle after the grant.
- Arithmetic:
  - Products are signed 2*DW bits; accumulator width ACCW = 2*DW + clog2(COL), so no internal overflow.
  - y registers are ACCW wide; output format per Optional Feature.
- Address arithmetic is modulo 2^AW; base + index wraps silently past the top of memory.
- cmd_valid while busy: not accepted; the host must hold the command until cmd_ready.

Optional Feature:
- Macro: LILME_SAT_EN.
- Defined: STORE saturates y[r] to signed DW range, i.e. [-2^(DW-1), 2^(DW-1)-1].
- Undefined: STORE writes the low DW bits of y[r] (wrap/truncate).

Test Plan:
- Reset mid-LOAD_A (after 3 of 16 grants), deassert, then idle: mem_req=0 immediately, busy=0, no done pulse, A all zero.
- LOAD_A at 0x100 with mem[0x100+i]=i+1, LOAD_B at 0x200 with b=1,1,1,1, MULT, STORE at 0x300 (random gnt/rvalid delays 0-3 cycles):
  - Memory reads back 10, 26, 42, 58.
  - MULT done exactly 17 cycles after accept.
- DW=16, A=all 0x7FFF, b=all 0x7FFF, MULT+STORE: with LILME_SAT_EN every word is 0x7FFF; without it every word is 0x0004 (low 16 bits of 4·0x3FFF0001).
- LOAD_B with cmd_addr=0xFFFF_FFFE, AW=32: reads issued to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- cmd_op=110 from IDLE: err pulses one cycle, done stays 0, cmd_ready back to 1 next cycle; cmd_valid during MULT is held off (cmd_ready=0) and accepted only after done.
- CLEAR after a loaded MULT, then STORE: all ROW words written as 0; stray mem_rvalid pulses injected while in MAC leave y unchanged.
